// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector of a small combinational
// block, samples its output once per vector and scores it against a golden table.
module truth_table_sweeper #(
    parameter int                      N_IN   = 4,
    parameter int                      HOLD   = 20,
    parameter int                      SETTLE = 1,
    parameter logic [(2**N_IN)-1:0]    GOLDEN = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            mode,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            fail_valid
);

    // state | meaning
    // IDLE  | waiting for start; dut_in parked at 0, results of last sweep held
    // RUN   | driving vec for HOLD cycles each, sampling at hold_cnt == SETTLE
    // DONE  | one-cycle done pulse; restart if mode=1, else back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   SETTLE_C  = HW'(SETTLE);
    localparam logic [HW-1:0]   LAST_HOLD = HW'(HOLD - 1);
    localparam logic [N_IN-1:0] LAST_VEC  = {N_IN{1'b1}};

    state_t          state;
    logic [N_IN-1:0] vec;
    logic [HW-1:0]   hold_cnt;
    logic            sample_hit;
    logic [N_IN:0]   err_next;

    // err_next folds in the current sample so a miss on the very last sample
    // still lands in pass at the DONE transition.
    always_comb begin
        sample_hit = 1'b0;
        if (state == RUN && hold_cnt == SETTLE_C && dut_out != GOLDEN[vec]) begin
            sample_hit = 1'b1;
        end
        err_next = err_count + (N_IN+1)'(sample_hit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            hold_cnt   <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else if (abort && state != IDLE) begin
            state    <= IDLE;
            vec      <= '0;
            hold_cnt <= '0;
            dut_in   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= RUN;
                        vec        <= '0;
                        hold_cnt   <= '0;
                        dut_in     <= '0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_valid <= 1'b0;
                    end
                end

                RUN: begin
                    err_count <= err_next;
                    if (sample_hit && !fail_valid) begin
                        first_fail <= vec;
                        fail_valid <= 1'b1;
                    end
                    if (hold_cnt == LAST_HOLD) begin
                        hold_cnt <= '0;
                        if (vec == LAST_VEC) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            vec    <= vec + N_IN'(1);
                            dut_in <= vec + N_IN'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end

                DONE: begin
                    done     <= 1'b0;
                    vec      <= '0;
                    hold_cnt <= '0;
                    dut_in   <= '0;
                    if (mode) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_valid <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Clocked, self-checking exhaustive stimulus engine for N-input, single-output combinational lab blocks.
- Drives every input vector 0..2**N_IN-1 in ascending order and holds each for HOLD cycles.
- Samples the DUT output after a settle delay and compares it against a parameterised golden truth table.
- Reports mismatch count, first failing vector, and pass/done status; single-sweep and continuous modes.

Parameters:
- N_IN, 4: number of DUT inputs; sweep length 2**N_IN vectors.
- HOLD, 20: cycles each vector is held; must be >= 2.
- SETTLE, 1: cycles after a vector is applied before dut_out is sampled; 0 <= SETTLE < HOLD.
- GOLDEN, 16'h0000: expected output; bit k = expected dut_out for vector k; width 2**N_IN.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  terminate sweep immediately; no done pulse
- mode  in  1  0 = single sweep, 1 = continuous (auto-restart)
- dut_in  out  N_IN  vector driven to DUT
- dut_out  in  1  DUT response
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  last completed sweep had zero mismatches
- err_count  out  N_IN+1  mismatches in current/last sweep; max 2**N_IN, no overflow
- first_fail  out  N_IN  lowest vector that mismatched in current/last sweep
- fail_valid  out  1  first_fail holds a valid value

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; all outputs are 0 (dut_in, busy, done, pass, err_count, first_fail, fail_valid). This applies from any state, including mid-sweep.
- States: IDLE, RUN, DONE. Internal counters: vec (N_IN bits) and hold_cnt (0..HOLD-1).
- IDLE, start=1 at edge t:
  - At t+1: RUN, busy=1, dut_in=0, hold_cnt=0.
  - err_count, first_fail, fail_valid and pass are cleared.
- IDLE, start=0: hold state. dut_in stays 0; results remain stable.
- RUN:
  - dut_in = vec. hold_cnt increments each cycle.
  - Sample point: in the cycle where hold_cnt==SETTLE, dut_out is compared with GOLDEN[vec].
  - On mismatch: err_count += 1. If fail_valid=0, also first_fail<=vec and fail_valid<=1.
  - When hold_cnt==HOLD-1: hold_cnt<=0. If vec == 2**N_IN-1, go to DONE; otherwise vec<=vec+1.
  - Length: exactly 2**N_IN*HOLD cycles in RUN.
- DONE (one cycle):
  - done=1, busy=0, pass=(err_count==0). dut_in holds the last vector.
  - Next state: if mode=0, IDLE with dut_in<=0. If mode=1, RUN, with vec, hold_cnt, err_count, first_fail and fail_valid cleared; busy=1 next cycle.
  - Continuous period: 2**N_IN*HOLD+1 cycles between done pulses.
  - pass holds its value until the next start is accepted or the next DONE.
- mode is sampled only in the DONE cycle.
- abort=1 in RUN or DONE:
  - Next state IDLE; busy=0, done=0, pass=0, dut_in=0.
  - err_count, first_fail and fail_valid keep their partial-sweep values.
- abort=1 in IDLE: no effect.
- Priority: rst_n > abort > start.
- start while RUN/DONE: ignored (no restart, no extra done).
- A mismatch sampled in the final hold_cnt of the last vector is counted before DONE; pass reflects it.
- err_count is wide enough for all vectors failing (2**N_IN); no saturation logic.

Test Plan (N_IN=4, HOLD=4, SETTLE=1, GOLDEN=16'hF0F0 unless stated):
- Ideal DUT model (dut_out=GOLDEN[dut_in]), mode=0, start one cycle -> busy for 64 cycles; done pulses once in cycle 65 after start; pass=1, err_count=0, fail_valid=0; dut_in=0 afterwards.
- Stuck-at-0 DUT -> 8 mismatches (vectors 4-7, 12-15); err_count=8, first_fail=4, fail_valid=1, pass=0 at done.
- Wrong only at vector 15 (last vector, final sample) -> err_count=1, first_fail=15, pass=0 in the done cycle.
- start re-pulsed at vectors 3 and 9, and start held high throughout -> exactly one done per 65-cycle window; vec sequence is uninterrupted 0..15.
- abort asserted while dut_in=5 -> next cycle busy=0, dut_in=0, no done; with stuck-at-0 DUT, err_count=1, first_fail=4 retained; pass=0.
- mode=1 with ideal DUT -> done pulses 65 cycles apart, busy low only in the DONE cycles. Then rst_n=0 for one edge while dut_in=10 -> all outputs 0 after that edge; IDLE until the next start.
